// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC pipeline front end:
// PC width, branch controller state encoding and the stall counts
// each kind of in-flight producer costs a branch in ID.
package risc_pkg;

   localparam int PC_W = 16;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   localparam logic [1:0] STALL_NONE     = 2'd0;
   localparam logic [1:0] STALL_EX_LOAD  = 2'd2;
   localparam logic [1:0] STALL_EX_ALU   = 2'd1;
   localparam logic [1:0] STALL_MEM_LOAD = 2'd1;

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle between the ID stage and the branch controller: decoded
// branch/jump controls and operands in, fetch PC and pipeline
// control strobes out.
interface branch_ctrl_if #(
   parameter int PC_W = risc_pkg::PC_W
) ();

   logic            id_valid;
   logic            is_beq;
   logic            is_bne;
   logic            is_jmp;
   logic            equal;
   logic [PC_W-1:0] pc_id;
   logic [PC_W-1:0] imm;
   logic [PC_W-1:0] jtarget;
   logic            ex_dep;
   logic            ex_load_dep;
   logic            mem_load_dep;
   logic [PC_W-1:0] pc_out;
   logic            stall;
   logic            flush;
   logic            taken;

   modport master (
      output id_valid, is_beq, is_bne, is_jmp, equal,
      output pc_id, imm, jtarget,
      output ex_dep, ex_load_dep, mem_load_dep,
      input  pc_out, stall, flush, taken
   );

   modport slave (
      input  id_valid, is_beq, is_bne, is_jmp, equal,
      input  pc_id, imm, jtarget,
      input  ex_dep, ex_load_dep, mem_load_dep,
      output pc_out, stall, flush, taken
   );

endinterface

// File: rtl/branch_target_adder.sv
// PC-relative branch target: pc_id + 1 + imm, wrapping at 2^PC_W.
module branch_target_adder #(
   parameter int PC_W = 16
) (
   input  logic [PC_W-1:0] pc_id_i,
   input  logic [PC_W-1:0] imm_i,
   output logic [PC_W-1:0] target_o
);

   localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

   // Offset is relative to the instruction after the branch; overflow
   // is simply dropped so targets wrap around the address space.
   always_comb begin
      target_o = pc_id_i + ONE + imm_i;
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and fetch PC sequencing. Resolves BEQ/BNE from
// the ID comparator, redirects on taken branches and jumps (squashing
// the one wrong-path fetch), and holds the pipeline while a branch
// operand is still being produced in EX/MEM.
module branch_ctrl
   import risc_pkg::*;
#(
   parameter int PC_W = risc_pkg::PC_W
) (
   input  logic          clk,
   input  logic          rst,
   branch_ctrl_if.slave  bus
);

   localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [1:0]      scnt_q, scnt_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] brTarget;
   logic            isBranch;
   logic            isJump;
   logic            branchCond;
   logic [1:0]      depCount;
   logic            stallD;
   logic            flushD;
   logic            takenD;

   branch_target_adder #(.PC_W(PC_W)) u_target (
      .pc_id_i  (bus.pc_id),
      .imm_i    (bus.imm),
      .target_o (brTarget)
   );

   // Decode the ID instruction and work out how many cycles the branch
   // must wait; a load still in EX costs more than an ALU op or a load
   // already in MEM. BEQ wins when both branch flags are set.
   always_comb begin
      isBranch   = bus.id_valid & (bus.is_beq | bus.is_bne);
      isJump     = bus.id_valid & bus.is_jmp;
      branchCond = bus.is_beq ? bus.equal : ~bus.equal;
      if (bus.ex_load_dep) begin
         depCount = STALL_EX_LOAD;
      end else if (bus.ex_dep) begin
         depCount = STALL_EX_ALU;
      end else if (bus.mem_load_dep) begin
         depCount = STALL_MEM_LOAD;
      end else begin
         depCount = STALL_NONE;
      end
   end

   // Next-state and control strobes. The RUN cycle that detects the
   // hazard is itself the first stall cycle, so scnt counts only the
   // extra cycles spent in STALL; a one-cycle hazard never leaves RUN
   // and the held branch is simply re-evaluated on the next cycle.
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      pc_d    = pc_q + ONE;
      stallD  = 1'b0;
      flushD  = 1'b0;
      takenD  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (isJump) begin
               pc_d   = bus.jtarget;
               takenD = 1'b1;
               flushD = 1'b1;
            end else if (isBranch && (depCount != STALL_NONE)) begin
               stallD  = 1'b1;
               pc_d    = pc_q;
               scnt_d  = depCount - 2'd1;
               state_d = (depCount > 2'd1) ? ST_STALL : ST_RUN;
            end else if (isBranch && branchCond) begin
               pc_d   = brTarget;
               takenD = 1'b1;
               flushD = 1'b1;
            end
         end
         ST_STALL: begin
            stallD = 1'b1;
            pc_d   = pc_q;
            if (scnt_q <= 2'd1) begin
               scnt_d  = 2'd0;
               state_d = ST_RUN;
            end else begin
               scnt_d = scnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            scnt_d  = 2'd0;
         end
      endcase
   end

   // Control strobes are quiet for as long as reset is held.
   always_comb begin
      bus.stall  = stallD & ~rst;
      bus.flush  = flushD & ~rst;
      bus.taken  = takenD & ~rst;
      bus.pc_out = pc_q;
   end

   // State, stall counter and fetch PC; reset overrides any stall or
   // redirect that is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         scnt_q  <= 2'd0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a table of single-cycle vectors
// issued from RUN, followed by hand-written multi-cycle sequences for
// the two-cycle load stall and reset during a stall.
module tb_branch_ctrl;

   localparam logic [1:0] INC  = 2'd0;
   localparam logic [1:0] ABS  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   typedef struct {
      logic        idValid;
      logic        isBeq;
      logic        isBne;
      logic        isJmp;
      logic        equal;
      logic [15:0] pcId;
      logic [15:0] imm;
      logic [15:0] jtarget;
      logic        exDep;
      logic        exLoadDep;
      logic        memLoadDep;
      logic        expStall;
      logic        expFlush;
      logic        expTaken;
      logic [1:0]  pcMode;
      logic [15:0] expPcAbs;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [15:0] expPc;
   vec_t vecs [18];

   branch_ctrl_if bus ();

   branch_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.id_valid     = v.idValid;
      bus.is_beq       = v.isBeq;
      bus.is_bne       = v.isBne;
      bus.is_jmp       = v.isJmp;
      bus.equal        = v.equal;
      bus.pc_id        = v.pcId;
      bus.imm          = v.imm;
      bus.jtarget      = v.jtarget;
      bus.ex_dep       = v.exDep;
      bus.ex_load_dep  = v.exLoadDep;
      bus.mem_load_dep = v.memLoadDep;
   endtask

   task automatic checkCtl(input string tag, input logic s, input logic f, input logic t);
      checkOutput({tag, ".stall"}, {15'd0, bus.stall}, {15'd0, s});
      checkOutput({tag, ".flush"}, {15'd0, bus.flush}, {15'd0, f});
      checkOutput({tag, ".taken"}, {15'd0, bus.taken}, {15'd0, t});
   endtask

   function automatic vec_t branchVec(input logic beq, input logic bne, input logic eq,
                                      input logic [15:0] pcId, input logic [15:0] imm,
                                      input logic exD, input logic exL, input logic memL);
      vec_t v;
      v = '{1'b1, beq, bne, 1'b0, eq, pcId, imm, 16'h0000, exD, exL, memL,
            1'b0, 1'b0, 1'b0, INC, 16'h0000};
      return v;
   endfunction

   initial begin
      vec_t idle;
      vec_t v;
      checks = 0;
      errors = 0;
      idle = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, INC, 16'h0};

      vecs[0]  = idle;
      vecs[1]  = idle;
      vecs[2]  = idle;
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hFFFC, 16'h1234, 1'b1, 1'b1, 1'b1,
                   1'b0, 1'b0, 1'b0, INC, 16'h0};
      vecs[4]  = branchVec(1'b1, 1'b0, 1'b1, 16'h0010, 16'hFFFC, 1'b0, 1'b0, 1'b0);
      vecs[4].expFlush = 1'b1; vecs[4].expTaken = 1'b1; vecs[4].pcMode = ABS; vecs[4].expPcAbs = 16'h000D;
      vecs[5]  = branchVec(1'b1, 1'b0, 1'b0, 16'h0010, 16'hFFFC, 1'b0, 1'b0, 1'b0);
      vecs[6]  = branchVec(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0002, 1'b0, 1'b0, 1'b0);
      vecs[7]  = branchVec(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0002, 1'b0, 1'b0, 1'b0);
      vecs[7].expFlush = 1'b1; vecs[7].expTaken = 1'b1; vecs[7].pcMode = ABS; vecs[7].expPcAbs = 16'h0043;
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0002, 16'h1234, 1'b1, 1'b0, 1'b0,
                   1'b0, 1'b1, 1'b1, ABS, 16'h1234};
      vecs[9]  = branchVec(1'b1, 1'b1, 1'b1, 16'h0100, 16'h0010, 1'b0, 1'b0, 1'b0);
      vecs[9].expFlush = 1'b1; vecs[9].expTaken = 1'b1; vecs[9].pcMode = ABS; vecs[9].expPcAbs = 16'h0111;
      vecs[10] = branchVec(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0010, 1'b0, 1'b0, 1'b0);
      vecs[11] = branchVec(1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0003, 1'b0, 1'b0, 1'b0);
      vecs[11].expFlush = 1'b1; vecs[11].expTaken = 1'b1; vecs[11].pcMode = ABS; vecs[11].expPcAbs = 16'h0002;
      vecs[12] = branchVec(1'b1, 1'b0, 1'b1, 16'h0050, 16'h0001, 1'b1, 1'b0, 1'b0);
      vecs[12].expStall = 1'b1; vecs[12].pcMode = HOLD;
      vecs[13] = branchVec(1'b1, 1'b0, 1'b1, 16'h0050, 16'h0001, 1'b0, 1'b0, 1'b0);
      vecs[13].expFlush = 1'b1; vecs[13].expTaken = 1'b1; vecs[13].pcMode = ABS; vecs[13].expPcAbs = 16'h0052;
      vecs[14] = branchVec(1'b0, 1'b1, 1'b0, 16'h0060, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      vecs[14].expStall = 1'b1; vecs[14].pcMode = HOLD;
      vecs[15] = branchVec(1'b0, 1'b1, 1'b0, 16'h0060, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      vecs[15].expFlush = 1'b1; vecs[15].expTaken = 1'b1; vecs[15].pcMode = ABS; vecs[15].expPcAbs = 16'h0060;
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0,
                   1'b0, 1'b1, 1'b1, ABS, 16'hFFFF};
      vecs[17] = idle;

      // Reset with a jump presented: strobes must stay low.
      rst = 1'b1;
      v = idle;
      v.idValid = 1'b1; v.isJmp = 1'b1; v.jtarget = 16'hABCD;
      applyStimulus(v);
      #2;
      checkCtl("inReset", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("resetPc", bus.pc_out, 16'h0000);
      rst = 1'b0;
      expPc = 16'h0000;

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
         #2;
         checkCtl($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expFlush, vecs[i].expTaken);
         @(posedge clk); #1;
         case (vecs[i].pcMode)
            ABS:     expPc = vecs[i].expPcAbs;
            HOLD:    expPc = expPc;
            default: expPc = expPc + 16'h0001;
         endcase
         checkOutput($sformatf("vec%0d.pc", i), bus.pc_out, expPc);
      end

      // BNE behind a load in EX: two stall cycles, then taken.
      v = branchVec(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0005, 1'b0, 1'b1, 1'b0);
      applyStimulus(v);
      #2;
      checkCtl("ldStall1", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("ldStall1.pc", bus.pc_out, expPc);
      bus.ex_load_dep = 1'b0;
      #2;
      checkCtl("ldStall2", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("ldStall2.pc", bus.pc_out, expPc);
      #2;
      checkCtl("ldResolve", 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      checkOutput("ldResolve.pc", bus.pc_out, 16'h0026);

      // Reset arriving during the second load-stall cycle.
      v = branchVec(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(v);
      #2;
      checkCtl("rsStall1", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.ex_load_dep = 1'b0;
      #1;
      checkCtl("rsStall2", 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checkCtl("rsAsserted", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("rsPc", bus.pc_out, 16'h0000);
      rst = 1'b0;
      #1;
      checkCtl("rsRun", 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      checkOutput("rsRun.pc", bus.pc_out, 16'h0031);

      applyStimulus(idle);
      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
